pipe_ctrl: RTL
==============

PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 Parameter DW, default 32, width of jump address and stall counter.
REQ-002 Parameter MEM_TMO, default 16, memory-wait timeout in cycles, legal range 2..255.
REQ-003 clk  input  1  single clock, all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 jump_en_i  input  1  EX stage requests redirect.
REQ-006 jump_addr_i  input  DW  redirect target.
REQ-007 load_use_i  input  1  ID stage detects load-use hazard.
REQ-008 div_start_i  input  1  EX issues multi-cycle divide.
REQ-009 div_ready_i  input  1  divider result valid.
REQ-010 mem_req_i  input  1  MEM stage data-bus request.
REQ-011 mem_ack_i  input  1  data-bus acknowledge.
REQ-012 hold_pc_o, hold_if_id_o, hold_id_ex_o, hold_ex_mem_o  output  1 each  freeze PC / pipeline registers.
REQ-013 flush_if_id_o, flush_id_ex_o  output  1 each  load reset value into pipeline registers.
REQ-014 jump_en_o  output  1  PC redirect strobe; jump_addr_o  output  DW  redirect target.
REQ-015 bus_err_o  output  1  one-cycle memory timeout pulse.
REQ-016 stall_cnt_o  output  DW  total stall cycles since reset.

Function
REQ-017 FSM states RUN, DIV_BUSY, MEM_WAIT; state, pending-jump and counters registered; hold/flush/jump outputs combinational from state, registers and inputs.
REQ-018 RUN, priority high to low: pending jump, jump_en_i, mem wait, div start, load-use.
REQ-019 RUN, pend_vld=1: jump_en_o=1, jump_addr_o=pend_addr, flush_if_id_o=flush_id_ex_o=1, no holds; pend_vld cleared next edge; jump_en_i that cycle ignored.
REQ-020 RUN, jump_en_i=1: jump_en_o=1, jump_addr_o=jump_addr_i, flush_if_id_o=flush_id_ex_o=1, load_use_i ignored.
REQ-021 RUN, mem_req_i=1 and mem_ack_i=0: all four holds asserted, next state MEM_WAIT, timeout counter cleared to 0.
REQ-022 RUN, div_start_i=1: hold_pc_o, hold_if_id_o, hold_id_ex_o asserted, next state DIV_BUSY.
REQ-023 RUN, load_use_i=1 only: hold_pc_o=hold_if_id_o=1, flush_id_ex_o=1 (bubble), stay RUN.
REQ-024 DIV_BUSY: hold_pc_o, hold_if_id_o, hold_id_ex_o asserted while div_ready_i=0; cycle with div_ready_i=1 releases all holds, next state RUN.
REQ-025 MEM_WAIT: all four holds asserted while mem_ack_i=0, timeout counter increments each cycle; mem_ack_i=1 releases holds that cycle, next state RUN.
REQ-026 MEM_WAIT, counter = MEM_TMO-1 and mem_ack_i=0: holds released, bus_err_o=1 for that cycle, next state RUN.
REQ-027 Flush outputs and jump_en_o never asserted in DIV_BUSY or MEM_WAIT.
REQ-028 jump_en_i=1 in DIV_BUSY or MEM_WAIT with pend_vld=0: pend_vld<=1, pend_addr<=jump_addr_i; if pend_vld=1, the new request is ignored (oldest wins).
REQ-029 Pending jump issued in first RUN cycle after wait ends, per REQ-019.
REQ-030 jump_addr_o = 0 whenever jump_en_o=0.
REQ-031 stall_cnt_o increments by 1 each cycle hold_pc_o=1; saturates at all-ones, no wrap.

Reset
REQ-032 rst=1 forces immediately, independent of clk: state RUN, pend_vld=0, pend_addr=0, timeout counter 0, stall_cnt_o=0.
REQ-033 During reset all hold, flush, jump and bus_err outputs are 0; jump_addr_o=0.
REQ-034 Reset asserted mid-DIV_BUSY or MEM_WAIT discards any pending jump; first cycle after release behaves as RUN.

Verification
REQ-035 jump_en_i=1, jump_addr_i=0x80 with load_use_i=1 in RUN -> jump_en_o=1, jump_addr_o=0x80, both flushes=1, stall_cnt_o unchanged.
REQ-036 div_start_i pulse, div_ready_i after 5 cycles -> holds on 6 cycles (start through cycle before ready), released on ready cycle, stall_cnt_o=6.
REQ-037 Jump 0x100 during DIV_BUSY, then jump 0x200 -> after div_ready_i, next cycle jump_en_o=1, jump_addr_o=0x100 only; no flushes during wait.
REQ-038 mem_req_i=1, mem_ack_i held 0, MEM_TMO=16 -> holds for 16 cycles, bus_err_o=1 on 17th cycle exactly once, state RUN.
REQ-039 Async rst pulse mid-MEM_WAIT with pending jump -> outputs 0 before next clk edge; after release no jump_en_o, stall_cnt_o=0.

Source files
------------

// File: rtl/pipe_ctrl.sv
// Pipeline hazard controller: stalls, flushes and PC redirects.
// Tracks divide and memory waits, defers jumps that arrive during a wait.
module pipe_ctrl #(
  parameter int DW      = 32,
  parameter int MEM_TMO = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          jump_en_i,
  input  logic [DW-1:0] jump_addr_i,
  input  logic          load_use_i,
  input  logic          div_start_i,
  input  logic          div_ready_i,
  input  logic          mem_req_i,
  input  logic          mem_ack_i,
  output logic          hold_pc_o,
  output logic          hold_if_id_o,
  output logic          hold_id_ex_o,
  output logic          hold_ex_mem_o,
  output logic          flush_if_id_o,
  output logic          flush_id_ex_o,
  output logic          jump_en_o,
  output logic [DW-1:0] jump_addr_o,
  output logic          bus_err_o,
  output logic [DW-1:0] stall_cnt_o
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    DIV_BUSY = 2'd1,
    MEM_WAIT = 2'd2
  } state_t;

  localparam logic [7:0] TMO_LAST = 8'(MEM_TMO - 1);

  state_t          state_q, state_d;
  logic            pend_vld_q, pend_vld_d;
  logic [DW-1:0]   pend_addr_q, pend_addr_d;
  logic [7:0]      tmo_q, tmo_d;
  logic [DW-1:0]   stall_q;

  logic            hold_pc, hold_if_id, hold_id_ex, hold_ex_mem;
  logic            flush_if_id, flush_id_ex;
  logic            jump_en;
  logic [DW-1:0]   jump_addr;
  logic            bus_err;

  // State, pending jump and timeout registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= RUN;
      pend_vld_q  <= 1'b0;
      pend_addr_q <= '0;
      tmo_q       <= '0;
    end else begin
      state_q     <= state_d;
      pend_vld_q  <= pend_vld_d;
      pend_addr_q <= pend_addr_d;
      tmo_q       <= tmo_d;
    end
  end

  // Saturating count of cycles the PC was frozen
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_q <= '0;
    end else if (hold_pc && (stall_q != '1)) begin
      stall_q <= stall_q + 1'b1;
    end
  end

  // Next-state and hazard-response decode
  always_comb begin
    state_d     = state_q;
    pend_vld_d  = pend_vld_q;
    pend_addr_d = pend_addr_q;
    tmo_d       = tmo_q;
    hold_pc     = 1'b0;
    hold_if_id  = 1'b0;
    hold_id_ex  = 1'b0;
    hold_ex_mem = 1'b0;
    flush_if_id = 1'b0;
    flush_id_ex = 1'b0;
    jump_en     = 1'b0;
    jump_addr   = '0;
    bus_err     = 1'b0;

    unique case (state_q)
      RUN: begin
        if (pend_vld_q) begin
          jump_en     = 1'b1;
          jump_addr   = pend_addr_q;
          flush_if_id = 1'b1;
          flush_id_ex = 1'b1;
          pend_vld_d  = 1'b0;
        end else if (jump_en_i) begin
          jump_en     = 1'b1;
          jump_addr   = jump_addr_i;
          flush_if_id = 1'b1;
          flush_id_ex = 1'b1;
        end else if (mem_req_i && !mem_ack_i) begin
          hold_pc     = 1'b1;
          hold_if_id  = 1'b1;
          hold_id_ex  = 1'b1;
          hold_ex_mem = 1'b1;
          tmo_d       = '0;
          state_d     = MEM_WAIT;
        end else if (div_start_i) begin
          hold_pc     = 1'b1;
          hold_if_id  = 1'b1;
          hold_id_ex  = 1'b1;
          state_d     = DIV_BUSY;
        end else if (load_use_i) begin
          hold_pc     = 1'b1;
          hold_if_id  = 1'b1;
          flush_id_ex = 1'b1;
        end
      end

      DIV_BUSY: begin
        if (jump_en_i && !pend_vld_q) begin
          pend_vld_d  = 1'b1;
          pend_addr_d = jump_addr_i;
        end
        if (div_ready_i) begin
          state_d = RUN;
        end else begin
          hold_pc    = 1'b1;
          hold_if_id = 1'b1;
          hold_id_ex = 1'b1;
        end
      end

      MEM_WAIT: begin
        if (jump_en_i && !pend_vld_q) begin
          pend_vld_d  = 1'b1;
          pend_addr_d = jump_addr_i;
        end
        if (mem_ack_i) begin
          state_d = RUN;
        end else if (tmo_q == TMO_LAST) begin
          bus_err = 1'b1;
          state_d = RUN;
        end else begin
          hold_pc     = 1'b1;
          hold_if_id  = 1'b1;
          hold_id_ex  = 1'b1;
          hold_ex_mem = 1'b1;
          tmo_d       = tmo_q + 8'd1;
        end
      end

      default: begin
        state_d = RUN;
      end
    endcase
  end

  // Outputs forced quiet while reset is asserted
  always_comb begin
    hold_pc_o     = hold_pc     & ~rst;
    hold_if_id_o  = hold_if_id  & ~rst;
    hold_id_ex_o  = hold_id_ex  & ~rst;
    hold_ex_mem_o = hold_ex_mem & ~rst;
    flush_if_id_o = flush_if_id & ~rst;
    flush_id_ex_o = flush_id_ex & ~rst;
    jump_en_o     = jump_en     & ~rst;
    jump_addr_o   = rst ? '0 : jump_addr;
    bus_err_o     = bus_err     & ~rst;
    stall_cnt_o   = stall_q;
  end

endmodule
